// File: rtl/bpred_update_sched.sv
// bpred_update_sched
// ------------------
// Sits in front of the single-ported bpredTop prediction tables. After reset
// it sweeps every table index with a clear write, then queues execute-stage
// update requests in a small FIFO. Each cycle it decides whether the tables go
// to a fetch lookup or to the update at the FIFO head. Fetch normally wins.
// An update is forced through when the head is a mispredict, when the queue is
// full, or when the head has waited STARVE_LIMIT cycles.
//
// Handshakes (valid/ready):
//   push side : a request transfers on any cycle where execute_update_valid=1
//               and sched_full=0. While sched_full=1 the source holds its
//               request and its fields stable. The push is ignored.
//   issue side: bpred_update=1 means the head entry is consumed that cycle.
//               bpred_PC4/target/dir/miss/data/meta carry the head entry. The
//               head is popped on the same rising edge.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   execute_update_*            update request from execute (push side)
//   sched_full                  FIFO full, execute must hold
//   fetch_lookup_req            fetch wants the tables this cycle
//   soin_stall                  downstream stall, blocks update issue
//   bpred_update, bpred_*       update strobe plus head-entry fields
//   bpred_clear_we/_idx         table clear sweep write port
//   sched_fetch_stall           fetch lookup denied this cycle
//   sched_busy                  sweep in progress or FIFO non-empty
//   dbg_state                   FSM state (0 = CLEAR, 1 = RUN)
module bpred_update_sched #(
    parameter int DEPTH        = 4,
    parameter int IDX_W        = 8,
    parameter int STARVE_LIMIT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             execute_update_valid,
    input  logic [31:0]      execute_update_PC4,
    input  logic [31:0]      execute_update_target,
    input  logic             execute_update_dir,
    input  logic             execute_update_miss,
    input  logic [95:0]      execute_update_data,
    input  logic [3:0]       execute_update_meta,
    output logic             sched_full,
    input  logic             fetch_lookup_req,
    input  logic             soin_stall,
    output logic             bpred_update,
    output logic [31:0]      bpred_PC4,
    output logic [31:0]      bpred_target,
    output logic             bpred_dir,
    output logic             bpred_miss,
    output logic [95:0]      bpred_data,
    output logic [3:0]       bpred_meta,
    output logic             bpred_clear_we,
    output logic [IDX_W-1:0] bpred_clear_idx,
    output logic             sched_fetch_stall,
    output logic             sched_busy,
    output logic             dbg_state
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [ST_W-1:0]  STARVE_MAX = ST_W'(STARVE_LIMIT);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] target;
        logic        dir;
        logic        miss;
        logic [95:0] data;
        logic [3:0]  meta;
    } entry_t;

    state_t           state, state_next;
    logic [IDX_W-1:0] clear_idx;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [ST_W-1:0]  starve;

    entry_t           head;
    logic             head_valid;
    logic             push, pop, issue;
    logic             clear_we_int;

    assign head_valid = (count != '0);
    assign head       = mem[rd_ptr];
    assign sched_full = (count == CNT_FULL);
    assign push       = execute_update_valid && !sched_full;
    assign pop        = issue;

    // ---------------- FSM state register and sweep index ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_CLEAR;
            clear_idx <= '0;
        end else begin
            state <= state_next;
            // Wraps back to 0 on the last sweep cycle, so it idles at 0 in RUN.
            if (state == ST_CLEAR)
                clear_idx <= clear_idx + IDX_W'(1);
        end
    end

    // ---------------- FSM next state and arbitration ----------------
    always_comb begin
        state_next        = state;
        clear_we_int      = 1'b0;
        issue             = 1'b0;
        sched_fetch_stall = 1'b0;
        case (state)
            ST_CLEAR: begin
                clear_we_int      = 1'b1;
                sched_fetch_stall = 1'b1;
                if (clear_idx == '1)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                issue = head_valid && !soin_stall &&
                        (!fetch_lookup_req || head.miss ||
                         sched_full || (starve == STARVE_MAX));
                sched_fetch_stall = fetch_lookup_req && issue;
            end
            default: state_next = ST_CLEAR;
        endcase
    end

    // The clear write is masked while reset is held so that the table sees no
    // writes during reset. The first clear write lands on the first cycle
    // after release.
    assign bpred_clear_we  = clear_we_int && reset;
    assign bpred_clear_idx = bpred_clear_we ? clear_idx : '0;
    assign bpred_update    = issue;
    assign sched_busy      = (state == ST_CLEAR) || head_valid;
    assign dbg_state       = state;

    // ---------------- FIFO storage (data path, no reset needed) ----------------
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{pc4:    execute_update_PC4,
                             target: execute_update_target,
                             dir:    execute_update_dir,
                             miss:   execute_update_miss,
                             data:   execute_update_data,
                             meta:   execute_update_meta};
    end

    // ---------------- FIFO pointers, count, starve counter ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            starve <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap naturally.
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // The counter measures how long the current head has waited.
            // Stalled cycles and sweep cycles count as waiting too.
            if (!head_valid || issue)
                starve <= '0;
            else if (starve != STARVE_MAX)
                starve <= starve + ST_W'(1);
        end
    end

    // Head fields are zeroed when the FIFO is empty so that stale storage is never visible.
    assign bpred_PC4    = head_valid ? head.pc4    : '0;
    assign bpred_target = head_valid ? head.target : '0;
    assign bpred_dir    = head_valid ? head.dir    : 1'b0;
    assign bpred_miss   = head_valid ? head.miss   : 1'b0;
    assign bpred_data   = head_valid ? head.data   : '0;
    assign bpred_meta   = head_valid ? head.meta   : '0;

endmodule
